// File: rtl/hwce_engine.sv
// Streaming 2-lane KxK convolution engine: line buffer + window, Q8 MAC per tap,
// adder tree with partial-sum injection, AXI4-Stream in/out with global output stall.
module hwce_engine #(
    parameter int AXI_WIDTH       = 32,
    parameter int CONV_WIDTH      = 16,
    parameter int FILTER_SIZE     = 5,
    parameter int PIPE_STAGES_MAC = 1,
    parameter int PIPE_STAGES_ADD = 1,
    parameter int LINE_WIDTH      = 32
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    input  logic [FILTER_SIZE*FILTER_SIZE*CONV_WIDTH-1:0] weight_i,
    input  logic                                          clear_i,
    input  logic                                          start_i,
    input  logic [AXI_WIDTH-1:0]                          x_in_TDATA_i,
    input  logic [AXI_WIDTH/8-1:0]                        x_in_TSTRB_i,
    input  logic [AXI_WIDTH/8-1:0]                        x_in_TKEEP_i,
    input  logic                                          x_in_TLAST_i,
    input  logic                                          x_in_TID_i,
    input  logic                                          x_in_TDEST_i,
    input  logic                                          x_in_TUSER_i,
    input  logic                                          x_in_TVALID_i,
    output logic                                          x_in_TREADY_o,
    input  logic [AXI_WIDTH-1:0]                          y_in_TDATA_i,
    input  logic [AXI_WIDTH/8-1:0]                        y_in_TSTRB_i,
    input  logic [AXI_WIDTH/8-1:0]                        y_in_TKEEP_i,
    input  logic                                          y_in_TLAST_i,
    input  logic                                          y_in_TID_i,
    input  logic                                          y_in_TDEST_i,
    input  logic                                          y_in_TUSER_i,
    input  logic                                          y_in_TVALID_i,
    output logic                                          y_in_TREADY_o,
    output logic [AXI_WIDTH-1:0]                          y_out_TDATA_o,
    output logic [AXI_WIDTH/8-1:0]                        y_out_TSTRB_o,
    output logic [AXI_WIDTH/8-1:0]                        y_out_TKEEP_o,
    output logic                                          y_out_TLAST_o,
    output logic                                          y_out_TID_o,
    output logic                                          y_out_TDEST_o,
    output logic                                          y_out_TUSER_o,
    output logic                                          y_out_TVALID_o,
    input  logic                                          y_out_TREADY_i
);
    localparam int K          = FILTER_SIZE;
    localparam int KK         = K * K;
    localparam int CW         = CONV_WIDTH;
    localparam int PM         = PIPE_STAGES_MAC;
    localparam int PA         = PIPE_STAGES_ADD;
    localparam int SR_LEN     = (K - 1) * LINE_WIDTH + K + 1;
    localparam int FILL_WORDS = (SR_LEN + 1) / 2;
    localparam int CNT_W      = $clog2(FILL_WORDS + 1);
    localparam int STAGES     = 1 + PM + PA;

    logic en, acc;
    logic [CNT_W-1:0] fill_q;
    logic lbr_q;
    logic [STAGES:0] vld_pipe_q;
    logic [SR_LEN-1:0][CW-1:0] sr_q;
    logic [AXI_WIDTH-1:0] yin_s0_q;
    logic [1:0][KK-1:0][CW-1:0] x_filter, mac_d;
    logic [PM:0][1:0][KK-1:0][CW-1:0] mac_q;
    logic [PM:0][AXI_WIDTH-1:0] yin_mac_q;
    logic [1:0][CW-1:0] y_out_int;
    logic [AXI_WIDTH-1:0] out_data;
    logic signed [2*CW-1:0] prod;
    logic unused_prod;
    logic unused_sb;

    assign en            = start_i & ~clear_i & y_out_TREADY_i;
    assign x_in_TREADY_o = en & y_in_TVALID_i;
    assign y_in_TREADY_o = en & x_in_TVALID_i;
    assign acc           = en & x_in_TVALID_i & y_in_TVALID_i;

    assign unused_sb = ^{x_in_TSTRB_i, x_in_TKEEP_i, x_in_TLAST_i, x_in_TID_i, x_in_TDEST_i,
                         x_in_TUSER_i, y_in_TSTRB_i, y_in_TKEEP_i, y_in_TLAST_i, y_in_TID_i,
                         y_in_TDEST_i, y_in_TUSER_i};

    // Ready flag looks at the count before the current word is added.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fill_q <= '0;
            lbr_q  <= 1'b0;
        end else if (clear_i) begin
            fill_q <= '0;
            lbr_q  <= 1'b0;
        end else if (acc && !lbr_q) begin
            fill_q <= fill_q + 1'b1;
            if (fill_q == CNT_W'(FILL_WORDS - 1)) lbr_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)             vld_pipe_q <= '0;
        else if (clear_i)        vld_pipe_q <= '0;
        else if (y_out_TREADY_i) vld_pipe_q <= {vld_pipe_q[STAGES-1:0], acc & lbr_q};
    end

    // sr_q[0] is the newest pixel; line buffer and window form one shift chain.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sr_q     <= '0;
            yin_s0_q <= '0;
        end else if (acc) begin
            sr_q     <= {sr_q[SR_LEN-3:0], x_in_TDATA_i[CW-1:0], x_in_TDATA_i[2*CW-1:CW]};
            yin_s0_q <= y_in_TDATA_i;
        end
    end

    always_comb begin
        x_filter = '0;
        for (int l = 0; l < 2; l++)
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++)
                    x_filter[l][r*K+c] = sr_q[(K-1-r)*LINE_WIDTH + K - l - c];
    end

    always_comb begin
        mac_d       = '0;
        prod        = '0;
        unused_prod = 1'b0;
        for (int l = 0; l < 2; l++)
            for (int i = 0; i < KK; i++) begin
                prod = $signed(x_filter[l][i]) * $signed(weight_i[i*CW +: CW]);
                mac_d[l][i] = {prod[2*CW-1], prod[CW+6:8]};
                unused_prod = unused_prod ^ (^{prod[2*CW-2:CW+7], prod[7:0]});
            end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mac_q     <= '0;
            yin_mac_q <= '0;
        end else if (y_out_TREADY_i) begin
            mac_q[0]     <= mac_d;
            yin_mac_q[0] <= yin_s0_q;
            for (int j = 1; j <= PM; j++) begin
                mac_q[j]     <= mac_q[j-1];
                yin_mac_q[j] <= yin_mac_q[j-1];
            end
        end
    end

    always_comb begin
        y_out_int = '0;
        for (int l = 0; l < 2; l++) begin
            y_out_int[l] = yin_mac_q[PM][l*CW +: CW];
            for (int i = 0; i < KK; i++) y_out_int[l] = y_out_int[l] + mac_q[PM][l][i];
        end
    end

    generate
        if (PA == 0) begin : g_no_add
            assign out_data = y_out_int;
        end else begin : g_add
            logic [PA-1:0][AXI_WIDTH-1:0] add_q;
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) add_q <= '0;
                else if (y_out_TREADY_i) begin
                    add_q[0] <= y_out_int;
                    for (int j = 1; j < PA; j++) add_q[j] <= add_q[j-1];
                end
            end
            assign out_data = add_q[PA-1];
        end
    endgenerate

    assign y_out_TDATA_o  = out_data;
    assign y_out_TVALID_o = vld_pipe_q[STAGES];
    assign y_out_TSTRB_o  = '1;
    assign y_out_TKEEP_o  = '1;
    assign y_out_TLAST_o  = 1'b0;
    assign y_out_TID_o    = 1'b0;
    assign y_out_TDEST_o  = 1'b0;
    assign y_out_TUSER_o  = 1'b0;
endmodule

// File: tb/tb_hwce_engine.sv
// Scoreboard bench for hwce_engine: pixel-history model of the 2-lane window,
// expected words queued on accept and popped on each y_out handshake.
module tb_hwce_engine;
    localparam int K = 5, KK = 25, W = 32;
    localparam int M_IDLE = 0, M_FILL = 1, M_RV = 2, M_BP = 3, M_ALL = 4, M_DRAIN = 5, M_CLEAR = 6;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [KK*16-1:0] weight;
    logic clear, start, xv, yv, out_rdy;
    logic [31:0] xd, yd;
    logic x_rdy, y_rdy, o_vld, o_last, o_id, o_dest, o_user;
    logic [31:0] o_data;
    logic [3:0] o_strb, o_keep;

    hwce_engine dut (
        .clk_i(clk), .rst_ni(rst_n), .weight_i(weight), .clear_i(clear), .start_i(start),
        .x_in_TDATA_i(xd), .x_in_TSTRB_i(4'hF), .x_in_TKEEP_i(4'hF), .x_in_TLAST_i(1'b0),
        .x_in_TID_i(1'b0), .x_in_TDEST_i(1'b0), .x_in_TUSER_i(1'b0), .x_in_TVALID_i(xv),
        .x_in_TREADY_o(x_rdy),
        .y_in_TDATA_i(yd), .y_in_TSTRB_i(4'hF), .y_in_TKEEP_i(4'hF), .y_in_TLAST_i(1'b0),
        .y_in_TID_i(1'b0), .y_in_TDEST_i(1'b0), .y_in_TUSER_i(1'b0), .y_in_TVALID_i(yv),
        .y_in_TREADY_o(y_rdy),
        .y_out_TDATA_o(o_data), .y_out_TSTRB_o(o_strb), .y_out_TKEEP_o(o_keep),
        .y_out_TLAST_o(o_last), .y_out_TID_o(o_id), .y_out_TDEST_o(o_dest),
        .y_out_TUSER_o(o_user), .y_out_TVALID_o(o_vld), .y_out_TREADY_i(out_rdy)
    );

    int n_chk = 0, n_err = 0;
    logic [31:0] exp_q[$];
    logic [15:0] hist[$];
    logic [15:0] w[KK];
    int words_m, mode, cyc, first_v, n_out;
    bit lbr_m, hold_pend;
    logic [31:0] hold_d, first_d;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic set_weights(input bit rnd);
        for (int i = 0; i < KK; i++) begin
            w[i] = rnd ? 16'($urandom) : 16'h0100;
            weight[i*16 +: 16] = w[i];
        end
    endtask

    // Lane 1's newest pixel is the last one in the history; lane 0 sits one pixel earlier.
    function automatic logic [31:0] model_out(input logic [31:0] y);
        int n, idx;
        logic [15:0] s;
        logic signed [31:0] p;
        logic [15:0] res[2];
        n = hist.size();
        for (int l = 0; l < 2; l++) begin
            s = y[l*16 +: 16];
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++) begin
                    idx = n - 2 + l - (K-1-r)*W - (K-1-c);
                    p = $signed(hist[idx]) * $signed(w[r*K+c]);
                    s = s + {p[31], p[22:8]};
                end
            res[l] = s;
        end
        return {res[1], res[0]};
    endfunction

    task automatic tick();
        logic en;
        logic [31:0] e;
        @(negedge clk);
        clear = 1'b0; start = 1'b1; out_rdy = 1'b1;
        xd = $urandom; yd = $urandom;
        xv = ($urandom_range(0, 3) != 0); yv = ($urandom_range(0, 3) != 0);
        case (mode)
            M_IDLE:  begin start = 1'b0; xv = 1'b1; yv = 1'b1; end
            M_FILL:  begin xv = 1'b1; yv = 1'b1; xd = 32'h0100_0100; yd = '0; end
            M_BP:    begin xv = 1'b1; yv = 1'b1; out_rdy = ($urandom_range(0, 2) != 0); end
            M_ALL:   out_rdy = ($urandom_range(0, 3) != 0);
            M_DRAIN: start = 1'b0;
            M_CLEAR: begin clear = 1'b1; xv = 1'b1; yv = 1'b1; end
            default: ;
        endcase
        #1;
        en = start & ~clear & out_rdy;
        check("x_ready", x_rdy, en & yv);
        check("y_ready", y_rdy, en & xv);
        if (hold_pend) begin
            check("hold_valid", o_vld, 1'b1);
            check("hold_data", o_data, hold_d);
            hold_pend = 1'b0;
        end
        if (o_vld && out_rdy) begin
            if (exp_q.size() == 0) check("y_out_extra", o_vld, 1'b0);
            else begin
                e = exp_q.pop_front();
                check("y_out", o_data, e);
                check("y_side", {o_strb, o_keep, o_last, o_id, o_dest, o_user}, 12'hFF0);
                n_out++;
                if (first_v < 0) begin first_v = cyc; first_d = o_data; end
            end
        end else if (o_vld) begin
            hold_pend = 1'b1;
            hold_d = o_data;
        end
        if (en && xv && yv) begin
            hist.push_back(xd[15:0]);
            hist.push_back(xd[31:16]);
            if (lbr_m) exp_q.push_back(model_out(yd));
            words_m++;
            if (words_m >= ((K-1)*W + K + 2) / 2) lbr_m = 1'b1;
        end
        if (mode == M_CLEAR) begin
            hist.delete();
            words_m = 0;
            lbr_m = 1'b0;
        end
        cyc++;
    endtask

    task automatic run_fill();
        mode = M_FILL; cyc = 0; first_v = -1; first_d = '0;
        repeat (100) tick();
        check("fill_latency", 64'(first_v), 64'd71);
        check("fill_data", first_d, 32'h1900_1900);
    endtask

    task automatic drain();
        mode = M_DRAIN;
        repeat (12) tick();
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_clear();
        mode = M_CLEAR;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (i > 0) check("clear_valid", o_vld, 1'b0);
        end
        mode = M_IDLE;
        tick();
    endtask

    task automatic run_until(input int m, input int target, input int limit);
        int g;
        mode = m; n_out = 0; g = 0;
        while (n_out < target && g < limit) begin
            tick();
            g++;
        end
        check("out_count", 64'(n_out >= target), 64'd1);
    endtask

    initial begin
        mode = M_IDLE; clear = 1'b0; start = 1'b0; xv = 1'b0; yv = 1'b0; out_rdy = 1'b1;
        xd = '0; yd = '0; words_m = 0; lbr_m = 1'b0; hold_pend = 1'b0; cyc = 0;
        first_v = -1; n_out = 0;
        set_weights(1'b0);
        repeat (3) @(negedge clk);
        #1;
        check("rst_valid", o_vld, 1'b0);
        check("rst_data", o_data, 32'h0);
        check("rst_keep", o_keep, 4'hF);
        rst_n = 1'b1;
        repeat (5) tick();

        run_fill();
        drain();
        do_clear();
        set_weights(1'b1);
        run_until(M_RV, 500, 6000);
        run_until(M_BP, 300, 3000);
        run_until(M_ALL, 300, 4000);
        drain();
        do_clear();
        set_weights(1'b0);
        run_fill();
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
